// File: rtl/main_mem_ctl_if.sv
// Cache <-> main memory handshake bundle.
// The master side is the cache and the slave side is the memory controller.
interface main_mem_ctl_if;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic        MemReadDone;
  logic        MemWriteReady;
  logic [31:0] memReadData;
  logic        MemReadReady;
  logic        MemWriteDone;
  logic        busy;

  modport master (
    output memAddr, memWriteData, MemRead, MemWrite, MemReadDone, MemWriteReady,
    input  memReadData, MemReadReady, MemWriteDone, busy
  );

  modport slave (
    input  memAddr, memWriteData, MemRead, MemWrite, MemReadDone, MemWriteReady,
    output memReadData, MemReadReady, MemWriteDone, busy
  );
endinterface

// File: rtl/main_mem_ctl.sv
// Main memory controller: fixed-latency word store behind a four-phase
// read/write handshake with the cache. A request is latched on acceptance,
// serviced after a fixed latency, held until the cache acknowledges, and
// the controller then waits for the request lines to drop before idling.
module main_mem_ctl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned READ_LAT    = 4,
  parameter int unsigned WRITE_LAT   = 4
) (
  input logic           clk,
  input logic           reset,
  main_mem_ctl_if.slave bus
);
  localparam int unsigned IW     = $clog2(DEPTH_WORDS);
  localparam int unsigned MAXLAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CW     = (MAXLAT < 2) ? 1 : $clog2(MAXLAT);
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LAT - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_HOLD, WR_WAIT, WR_HOLD, RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rrdy_q, rrdy_d;
  logic          wdone_q, wdone_d;
  logic          busy_q, busy_d;
  logic          wr_commit;
  logic [IW-1:0] addr_idx;

  // Backing store: zero at power-up, deliberately untouched by reset.
  logic [31:0] store_q [DEPTH_WORDS] = '{default: '0};

  // Upper address bits alias onto the store and byte offset bits are ignored.
  assign addr_idx = bus.memAddr[IW+1:2];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.memAddr[31:IW+2], bus.memAddr[1:0]};

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rrdy_d    = rrdy_q;
    wdone_d   = wdone_q;
    wr_commit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.MemWrite && bus.MemWriteReady) begin
          idx_d   = addr_idx;
          wdata_d = bus.memWriteData;
          cnt_d   = WR_LOAD;
          state_d = WR_WAIT;
        end else if (bus.MemRead) begin
          idx_d   = addr_idx;
          cnt_d   = RD_LOAD;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = store_q[idx_q];
          rrdy_d  = 1'b1;
          state_d = RD_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_HOLD: begin
        if (bus.MemReadDone) begin
          rrdy_d  = 1'b0;
          state_d = RELEASE;
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          // A reset landing on the commit edge must leave the store untouched.
          wr_commit = !reset;
          wdone_d   = 1'b1;
          state_d   = WR_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WR_HOLD: begin
        if (!bus.MemWriteReady) begin
          wdone_d = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.MemRead && !bus.MemWrite) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rrdy_q  <= 1'b0;
      wdone_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rrdy_q  <= rrdy_d;
      wdone_q <= wdone_d;
      busy_q  <= busy_d;
    end
  end

  // Store write port, fired on the final latency cycle of a write.
  always_ff @(posedge clk) begin
    if (wr_commit) store_q[idx_q] <= wdata_q;
  end

  assign bus.memReadData  = rdata_q;
  assign bus.MemReadReady = rrdy_q;
  assign bus.MemWriteDone = wdone_q;
  assign bus.busy         = busy_q;
endmodule
